// File: rtl/cpu_defs.sv
// Shared CPU-wide constants and pipeline register layouts.
package cpu_defs;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY  = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS = 4096;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exccode;
    logic        bd;
  } if_id_t;

  // Source of the next fetch PC, in priority order.
  typedef enum logic [2:0] {
    PC_SEL_EXC,
    PC_SEL_ERET,
    PC_SEL_HOLD,
    PC_SEL_REDIRECT,
    PC_SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register with hold (stall) and clear (bubble) controls.
// Clear takes priority over hold so an exception squashes a stalled stage.
module if_id_reg
  import cpu_defs::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  // Stage register: reset, then bubble, then hold, else capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory, tags
// fetch-address errors (AdEL) and fills the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET   = cpu_defs::PC_RESET,
  parameter logic [31:0] EXC_ENTRY  = cpu_defs::EXC_ENTRY,
  parameter logic [31:0] IMEM_BASE  = cpu_defs::IMEM_BASE,
  parameter int unsigned IMEM_WORDS = cpu_defs::IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        id_is_branch,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [4:0]  if_id_exccode,
  output logic        if_id_bd
);

  import cpu_defs::*;

  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(IMEM_WORDS * 4) - 32'd4;

  pc_sel_e     pc_sel;
  logic [31:0] pc_next;
  logic        adel;
  if_id_t      stage_d;
  if_id_t      stage_q;

  assign imem_addr = pc;

  // AdEL: misaligned or outside the instruction memory window.
  always_comb begin
    adel = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_LAST);
  end

  // Choose the PC source by priority and form the next PC.
  always_comb begin
    pc_sel  = PC_SEL_SEQ;
    pc_next = pc + 32'd4;
    if (flush) begin
      pc_sel = PC_SEL_EXC;
    end else if (eret) begin
      pc_sel = PC_SEL_ERET;
    end else if (stall) begin
      pc_sel = PC_SEL_HOLD;
    end else if (redirect) begin
      pc_sel = PC_SEL_REDIRECT;
    end
    case (pc_sel)
      PC_SEL_EXC:      pc_next = EXC_ENTRY;
      PC_SEL_ERET:     pc_next = epc;
      PC_SEL_HOLD:     pc_next = pc;
      PC_SEL_REDIRECT: pc_next = redirect_target;
      default:         pc_next = pc + 32'd4;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

  // Word presented to IF/ID; a faulting fetch becomes a nop carrying AdEL.
  always_comb begin
    stage_d.instr   = adel ? NOP : imem_rdata;
    stage_d.pc      = pc;
    stage_d.exccode = adel ? EXC_ADEL : EXC_NONE;
    stage_d.bd      = id_is_branch;
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .hold  (stall),
    .clear (flush | eret),
    .d     (stage_d),
    .q     (stage_q)
  );

  assign if_id_instr   = stage_q.instr;
  assign if_id_pc      = stage_q.pc;
  assign if_id_exccode = stage_q.exccode;
  assign if_id_bd      = stage_q.bd;

endmodule
